// File: rtl/pixel_mem_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_mem_sched_if
//  Brief    : Bundle of the CPU load port, the image stream port and the data
//             memory read port served by pixel_mem_sched.
//  Revision : 1.0  initial release
// ============================================================================
interface pixel_mem_sched_if;
    // CPU load path
    logic        cpu_req;
    logic [19:0] cpu_addr;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    // image streamer
    logic        str_start;
    logic [19:0] str_base;
    logic [19:0] str_len;
    logic        str_busy;
    logic        str_err;
    logic        str_done;
    logic        str_valid;
    logic        str_ready;
    logic [7:0]  str_data;
    // data memory read port
    logic [19:0] mem_addr;
    logic [31:0] mem_rdata;

    // Requester / memory side
    modport master (
        output cpu_req, cpu_addr,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        output str_start, str_base, str_len, str_ready,
        input  str_busy, str_err, str_done, str_valid, str_data,
        input  mem_addr,
        output mem_rdata
    );

    // Scheduler side
    modport slave (
        input  cpu_req, cpu_addr,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        input  str_start, str_base, str_len, str_ready,
        output str_busy, str_err, str_done, str_valid, str_data,
        output mem_addr,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pixel_mem_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_mem_sched
//  Brief    : Read-port scheduler for the banked image memory. Arbitrates the
//             single combinational read port between CPU random loads and a
//             sequential burst streamer with a small output FIFO. Two-cycle
//             latency: grant -> registered mem_addr -> sampled mem_rdata.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_mem_sched #(
    parameter int MEM_DEPTH  = 307200,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pixel_mem_sched_if.slave  bus
);

    localparam logic [20:0]   C_MEM_DEPTH = 21'(MEM_DEPTH);
    localparam int            AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] C_LAST_SLOT = AW'(FIFO_DEPTH - 1);
    localparam logic          C_OWNER_CPU = 1'b0;
    localparam logic          C_OWNER_STR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } str_state_t;

    // streamer FSM state (owned by the single FSM always_ff)
    str_state_t  state_q;
    logic [19:0] ptr_q;
    logic [19:0] remaining_q;
    logic        str_done_q;
    logic        str_err_q;

    // arbitration / pipeline
    logic        last_owner_q, last_owner_d;
    logic [19:0] mem_addr_q,   mem_addr_d;
    logic        p1_cpu_q,     p1_cpu_d;
    logic        p1_err_q,     p1_err_d;
    logic        p1_str_q,     p1_str_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        cpu_err_q,    cpu_err_d;
    logic [31:0] cpu_rdata_q,  cpu_rdata_d;

    // stream output FIFO
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [7:0]    fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;

    logic        cpu_oor;
    logic        str_elig;
    logic        cpu_win;
    logic        str_win;
    logic        fifo_push;
    logic        fifo_pop;
    logic [20:0] start_sum;

    // Arbitration and issue: who owns the read port this cycle, and what gets registered
    always_comb begin
        cpu_oor   = {1'b0, bus.cpu_addr} >= C_MEM_DEPTH;
        start_sum = {1'b0, bus.str_base} + {1'b0, bus.str_len};
        // the in-flight stream read already has a FIFO slot reserved
        str_elig  = (state_q == S_RUN) &&
                    ((32'(fifo_count_q) + 32'(p1_str_q)) < 32'(FIFO_DEPTH));
        cpu_win   = bus.cpu_req && (!str_elig || (last_owner_q == C_OWNER_STR));
        str_win   = str_elig && !cpu_win;

        last_owner_d = last_owner_q;
        if (cpu_win) begin
            last_owner_d = C_OWNER_CPU;
        end else if (str_win) begin
            last_owner_d = C_OWNER_STR;
        end

        // an out-of-range CPU read keeps the memory address where it was
        mem_addr_d = mem_addr_q;
        if (cpu_win && !cpu_oor) begin
            mem_addr_d = bus.cpu_addr;
        end else if (str_win) begin
            mem_addr_d = ptr_q;
        end

        p1_cpu_d = cpu_win;
        p1_err_d = cpu_win && cpu_oor;
        p1_str_d = str_win;

        cpu_rvalid_d = p1_cpu_q;
        cpu_err_d    = p1_err_q;
        cpu_rdata_d  = (p1_cpu_q && !p1_err_q) ? bus.mem_rdata : 32'h0;
    end

    // Stream FIFO next state: stream reads land here one cycle after issue
    always_comb begin
        fifo_push = p1_str_q;
        fifo_pop  = (fifo_count_q != '0) && bus.str_ready;

        fifo_mem_d = fifo_mem_q;
        if (fifo_push) begin
            fifo_mem_d[wr_ptr_q] = bus.mem_rdata[7:0];
        end

        wr_ptr_d = wr_ptr_q;
        if (fifo_push) begin
            wr_ptr_d = (wr_ptr_q == C_LAST_SLOT) ? '0 : wr_ptr_q + AW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (fifo_pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST_SLOT) ? '0 : rd_ptr_q + AW'(1);
        end

        case ({fifo_push, fifo_pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // Datapath and FIFO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= C_OWNER_STR;
            mem_addr_q   <= '0;
            p1_cpu_q     <= 1'b0;
            p1_err_q     <= 1'b0;
            p1_str_q     <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            last_owner_q <= last_owner_d;
            mem_addr_q   <= mem_addr_d;
            p1_cpu_q     <= p1_cpu_d;
            p1_err_q     <= p1_err_d;
            p1_str_q     <= p1_str_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            fifo_mem_q   <= fifo_mem_d;
        end
    end

    // Streamer FSM: accept/reject bursts, walk the address range, drain the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            str_done_q  <= 1'b0;
            str_err_q   <= 1'b0;
        end else begin
            str_done_q <= 1'b0;
            str_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.str_start) begin
                        if (bus.str_len == '0) begin
                            str_done_q <= 1'b1;
                        end else if (start_sum > C_MEM_DEPTH) begin
                            str_err_q <= 1'b1;
                        end else begin
                            ptr_q       <= bus.str_base;
                            remaining_q <= bus.str_len;
                            state_q     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (str_win) begin
                        ptr_q       <= ptr_q + 20'd1;
                        remaining_q <= remaining_q - 20'd1;
                        if (remaining_q == 20'd1) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // nothing issues here, so an empty FIFO next cycle means the
                    // final byte is being handed off right now
                    if (fifo_count_d == '0) begin
                        str_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_gnt    = cpu_win;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_err    = cpu_err_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.str_busy   = (state_q != S_IDLE);
    assign bus.str_err    = str_err_q;
    assign bus.str_done   = str_done_q;
    assign bus.str_valid  = (fifo_count_q != '0);
    assign bus.str_data   = fifo_mem_q[rd_ptr_q];
    assign bus.mem_addr   = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_mem_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_mem_sched
//  Brief    : Self-checking bench for pixel_mem_sched: CPU read vector table
//             plus directed burst, arbitration, stall and reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_mem_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pixel_mem_sched_if bus ();

    pixel_mem_sched #(
        .MEM_DEPTH  (307200),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory image: byte 5 holds 8'hA7, every other byte a simple address hash
    function automatic logic [7:0] exp_byte(input logic [19:0] a);
        if (a == 20'd5) return 8'hA7;
        return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5};
    endfunction

    assign bus.mem_rdata = {24'h0, exp_byte(bus.mem_addr)};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rv_cnt   = 0;
    logic [7:0] got_q [$];
    int         cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe stream handshakes, done pulses and CPU responses
    always @(negedge clk) begin
        if (bus.str_valid && bus.str_ready) begin
            got_q.push_back(bus.str_data);
            cyc_q.push_back(cyc);
        end
        if (bus.str_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.cpu_rvalid) rv_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  data;
        logic        err;
    } cpu_vec_t;

    cpu_vec_t vecs [6];

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // entered and left at #1 after a rising edge
    task automatic cpu_read(input logic [19:0] a, input logic [7:0] ed, input logic ee,
                            input logic [19:0] exp_maddr);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        @(negedge clk);
        chk("cpu_gnt_c0", 32'(bus.cpu_gnt), 32'd1);
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_rvalid_c1", 32'(bus.cpu_rvalid), 32'd0);
        @(negedge clk);
        chk("cpu_rvalid_c2", 32'(bus.cpu_rvalid), 32'd1);
        chk("cpu_err", 32'(bus.cpu_err), 32'(ee));
        chk("cpu_rdata", bus.cpu_rdata, ee ? 32'h0 : {24'h0, ed});
        chk("mem_addr_after_read", 32'(bus.mem_addr), 32'(exp_maddr));
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [19:0] base, input logic [19:0] len);
        bus.str_start = 1'b1;
        bus.str_base  = base;
        bus.str_len   = len;
        @(posedge clk);
        #1 bus.str_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit);
        int n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_within_budget", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic check_burst(input logic [19:0] base, input int n);
        chk("burst_len", 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk($sformatf("burst_byte%0d", i), 32'(got_q[i]), 32'(exp_byte(base + 20'(i))));
        end
    endtask

    initial begin
        int t0;
        int d0;
        int rv0;
        logic [19:0] last_addr;

        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus.str_start = 1'b0;
        bus.str_base  = '0;
        bus.str_len   = '0;
        bus.str_ready = 1'b1;

        // addr, expected byte (hand-computed), expected err
        vecs[0] = '{20'd5,       8'hA7, 1'b0};
        vecs[1] = '{20'd307200,  8'h00, 1'b1};
        vecs[2] = '{20'd0,       8'h05, 1'b0};
        vecs[3] = '{20'd307199,  8'h15, 1'b0};
        vecs[4] = '{20'hFFFFF,   8'h00, 1'b1};
        vecs[5] = '{20'h12345,   8'h73, 1'b0};

        // ---- reset values ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_cpu_rdata",  bus.cpu_rdata,       32'd0);
        chk("rst_str_busy",   32'(bus.str_busy),   32'd0);
        chk("rst_str_valid",  32'(bus.str_valid),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- CPU vector table ----
        last_addr = '0;
        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].err) last_addr = vecs[i].addr;
            cpu_read(vecs[i].addr, vecs[i].data, vecs[i].err, last_addr);
        end

        // ---- plain burst across a bank boundary ----
        got_q.delete(); cyc_q.delete();
        d0 = done_cnt;
        start_burst(20'd64998, 20'd4);
        t0 = cyc;
        wait_done(d0, 40);
        check_burst(20'd64998, 4);
        if (cyc_q.size() == 4) begin
            chk("first_byte_cycle", 32'(cyc_q[0]), 32'(t0 + 2));
            for (int i = 1; i < 4; i++)
                chk("consecutive_bytes", 32'(cyc_q[i]), 32'(cyc_q[0] + i));
            chk("done_after_last", 32'(done_cyc), 32'(cyc_q[3] + 1));
        end
        chk("busy_after_done", 32'(bus.str_busy), 32'd0);

        // ---- alternation with CPU held ----
        do_reset();
        got_q.delete(); cyc_q.delete();
        d0  = done_cnt;
        rv0 = rv_cnt;
        start_burst(20'd1000, 20'd8);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 20'd100;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("alt_gnt%0d", k), 32'(bus.cpu_gnt), 32'((k % 2) == 0));
        end
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        wait_done(d0, 40);
        check_burst(20'd1000, 8);
        chk("alt_cpu_rvalids", 32'(rv_cnt - rv0), 32'd8);

        // ---- back-pressure stall ----
        got_q.delete(); cyc_q.delete();
        bus.str_ready = 1'b0;
        d0 = done_cnt;
        start_burst(20'd2000, 20'd10);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_mem_addr",  32'(bus.mem_addr),  32'd2003);
        chk("stall_valid",     32'(bus.str_valid), 32'd1);
        chk("stall_busy",      32'(bus.str_busy),  32'd1);
        chk("stall_no_pops",   32'(got_q.size()),  32'd0);
        bus.str_ready = 1'b1;
        wait_done(d0, 60);
        check_burst(20'd2000, 10);

        // ---- rejected and empty bursts ----
        start_burst(20'd307000, 20'd300);
        @(negedge clk);
        chk("bad_start_err",  32'(bus.str_err),  32'd1);
        chk("bad_start_busy", 32'(bus.str_busy), 32'd0);
        @(posedge clk); #1;
        start_burst(20'd10, 20'd0);
        @(negedge clk);
        chk("zero_len_done", 32'(bus.str_done), 32'd1);
        chk("zero_len_busy", 32'(bus.str_busy), 32'd0);
        @(posedge clk); #1;

        // ---- reset mid-burst with a CPU read in flight ----
        start_burst(20'd500, 20'd10);
        repeat (2) @(posedge clk);
        #1 bus.cpu_req = 1'b1; bus.cpu_addr = 20'd7;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        rst_n = 1'b0;
        d0  = done_cnt;
        rv0 = rv_cnt;
        #1;
        chk("midrst_busy",     32'(bus.str_busy),   32'd0);
        chk("midrst_valid",    32'(bus.str_valid),  32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr),   32'd0);
        chk("midrst_rvalid",   32'(bus.cpu_rvalid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete(); cyc_q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_done",   32'(done_cnt), 32'(d0));
        chk("midrst_no_rvalid", 32'(rv_cnt),   32'(rv0));
        chk("midrst_no_bytes",  32'(got_q.size()), 32'd0);

        // ---- fresh burst ending exactly at the top of memory ----
        d0 = done_cnt;
        start_burst(20'd307196, 20'd4);
        wait_done(d0, 40);
        check_burst(20'd307196, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
